// File: rtl/mor1kx_spr_gpr_master_pkg.sv
// Shared types for the SPR-bus GPR initiator.
// GPR group number and FSM encodings.
package mor1kx_spr_gpr_master_pkg;

  localparam logic [6:0] SPR_GPR_GROUP = 7'h2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDAT,
    ST_ACC,
    ST_RESP,
    ST_GAP
  } state_e;

endpackage

// File: rtl/mor1kx_spr_gpr_master_if.sv
// Debug command channel plus SPR bus of the GPR initiator.
// master = initiator view, slave = debug unit / responder view.
interface mor1kx_spr_gpr_master_if #(
  parameter int OPW   = 32,
  parameter int IDX_W = 5,
  parameter int LEN_W = 5
);

  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_we_i;
  logic [IDX_W-1:0] cmd_idx_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             wdat_valid_i;
  logic [OPW-1:0]   wdat_i;
  logic             wdat_ready_o;
  logic             rdat_valid_o;
  logic [OPW-1:0]   rdat_o;
  logic             rdat_ready_i;
  logic             done_o;
  logic             err_o;
  logic [15:0]      spr_bus_addr_o;
  logic             spr_bus_stb_o;
  logic             spr_bus_we_o;
  logic [OPW-1:0]   spr_bus_dat_o;
  logic             spr_gpr_ack_i;
  logic [OPW-1:0]   spr_gpr_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_idx_i, cmd_len_i,
    input  wdat_valid_i, wdat_i, rdat_ready_i,
    input  spr_gpr_ack_i, spr_gpr_dat_i,
    output cmd_ready_o, wdat_ready_o,
    output rdat_valid_o, rdat_o,
    output done_o, err_o,
    output spr_bus_addr_o, spr_bus_stb_o,
    output spr_bus_we_o, spr_bus_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_idx_i, cmd_len_i,
    output wdat_valid_i, wdat_i, rdat_ready_i,
    output spr_gpr_ack_i, spr_gpr_dat_i,
    input  cmd_ready_o, wdat_ready_o,
    input  rdat_valid_o, rdat_o,
    input  done_o, err_o,
    input  spr_bus_addr_o, spr_bus_stb_o,
    input  spr_bus_we_o, spr_bus_dat_o
  );

endinterface

// File: rtl/mor1kx_spr_gpr_master.sv
// SPR-bus initiator: sequences single/burst GPR accesses for the debug unit.
// Strobe held until ack; a one-cycle gap separates accesses.
module mor1kx_spr_gpr_master
  import mor1kx_spr_gpr_master_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH     = 32,
  parameter int OPTION_RF_ADDR_WIDTH     = 5,
  parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
  parameter int OPTION_LEN_WIDTH         = 5,
  parameter int TIMEOUT_CYCLES           = 255
) (
  input logic                     clk,
  input logic                     rst,
  mor1kx_spr_gpr_master_if.master bus
);

  localparam int OPW   = OPTION_OPERAND_WIDTH;
  localparam int IDX_W = OPTION_RF_ADDR_WIDTH
                       + OPTION_RF_NUM_SHADOW_GPR;
  localparam int LEN_W = OPTION_LEN_WIDTH;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic [LEN_W:0]   cnt_q;
  logic [TO_W-1:0]  to_q;
  logic [OPW-1:0]   dat_q;
  logic [OPW-1:0]   rdat_q;
  logic             done_q;
  logic             err_q;

  logic cmd_rdy;
  logic cmd_fire;
  logic wdat_fire;
  logic in_acc;
  logic ack;
  logic tmo;
  logic gap_end;
  logic acc_entry;

  assign cmd_rdy   = ~rst & (state_q == ST_IDLE);
  assign cmd_fire  = cmd_rdy & bus.cmd_valid_i;
  assign wdat_fire = (state_q == ST_WDAT) & bus.wdat_valid_i;
  assign in_acc    = state_q == ST_ACC;
  assign ack       = in_acc & bus.spr_gpr_ack_i;
  // An ack in the final allowed cycle still completes normally.
  assign tmo       = in_acc & ~bus.spr_gpr_ack_i
                   & (to_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign gap_end   = (state_q == ST_GAP) & (cnt_q == '0);
  assign acc_entry = (state_d == ST_ACC) & ~in_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_d = bus.cmd_we_i ? ST_WDAT : ST_ACC;
        end
      end
      ST_WDAT: begin
        if (bus.wdat_valid_i) begin
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (ack) begin
          state_d = we_q ? ST_GAP : ST_RESP;
        end else if (tmo) begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (bus.rdat_ready_i) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = we_q ? ST_WDAT : ST_ACC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready_o    = cmd_rdy;
    bus.wdat_ready_o   = state_q == ST_WDAT;
    bus.rdat_valid_o   = state_q == ST_RESP;
    bus.rdat_o         = rdat_q;
    bus.done_o         = done_q;
    bus.err_o          = err_q;
    bus.spr_bus_stb_o  = in_acc;
    bus.spr_bus_we_o   = in_acc & we_q;
    bus.spr_bus_dat_o  = dat_q;
    bus.spr_bus_addr_o = '0;
    if (in_acc) begin
      bus.spr_bus_addr_o = {SPR_GPR_GROUP, 9'(idx_q)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= '0;
      to_q   <= '0;
      dat_q  <= '0;
      rdat_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= gap_end | tmo;
      err_q  <= tmo;
      if (cmd_fire) begin
        we_q  <= bus.cmd_we_i;
        idx_q <= bus.cmd_idx_i;
        cnt_q <= {1'b0, bus.cmd_len_i} + (LEN_W+1)'(1);
      end
      if (wdat_fire) begin
        dat_q <= bus.wdat_i;
      end
      if (acc_entry) begin
        to_q <= '0;
      end else if (in_acc) begin
        to_q <= to_q + TO_W'(1);
      end
      if (ack) begin
        idx_q <= idx_q + IDX_W'(1);
        cnt_q <= cnt_q - (LEN_W+1)'(1);
        if (!we_q) begin
          rdat_q <= bus.spr_gpr_dat_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_spr_gpr_master.sv
// Bench for the GPR initiator with a behavioural responder that
// acks one cycle after strobe and registers its read data.
module tb_mor1kx_spr_gpr_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mor1kx_spr_gpr_master_if #(.OPW(32), .IDX_W(5), .LEN_W(5)) bus ();

  mor1kx_spr_gpr_master #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5),
    .OPTION_RF_NUM_SHADOW_GPR(0),
    .OPTION_LEN_WIDTH(5),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // responder
  logic [31:0] mem [32];
  logic        pend;
  logic        stall = 1'b0;
  logic        dead = 1'b0;
  logic [31:0] rd_q;

  assign bus.spr_gpr_ack_i = bus.spr_bus_stb_o & pend & ~stall & ~dead;
  assign bus.spr_gpr_dat_i = rd_q;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
  end

  always @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else pend <= bus.spr_bus_stb_o & ~bus.spr_gpr_ack_i & ~stall;
    rd_q <= mem[bus.spr_bus_addr_o[4:0]];
    if (bus.spr_gpr_ack_i && bus.spr_bus_we_o)
      mem[bus.spr_bus_addr_o[4:0]] <= bus.spr_bus_dat_o;
  end

  // write-word source
  logic [31:0] wq [$];
  logic        w_took = 1'b0;
  always @(negedge clk) begin
    if (w_took && wq.size() != 0) void'(wq.pop_front());
    bus.wdat_valid_i = wq.size() != 0;
    bus.wdat_i = (wq.size() != 0) ? wq[0] : 32'h0;
    w_took = bus.wdat_valid_i & bus.wdat_ready_o;
  end

  // read-word sink
  logic [31:0] rq [$];
  int          blk = 0;
  int          rdat_unstable = 0;
  logic        r_pv = 1'b0;
  logic        r_pr = 1'b0;
  logic [31:0] r_pd = '0;
  always @(negedge clk) begin
    bus.rdat_ready_i = (blk == 0);
    if (bus.rdat_valid_o) begin
      if (r_pv && !r_pr && bus.rdat_o != r_pd) rdat_unstable++;
      if (bus.rdat_ready_i) rq.push_back(bus.rdat_o);
      else blk--;
    end
    r_pv = bus.rdat_valid_o;
    r_pr = bus.rdat_ready_i;
    r_pd = bus.rdat_o;
  end

  // bus monitor
  logic [15:0] alog [$];
  int run = 0, max_run = 0, gap_viol = 0, unstable = 0;
  int done_cnt = 0, err_cnt = 0, proto = 0, rv_cyc = 0;
  logic        p_ack = 0, p_stb = 0, p_we = 0;
  logic [15:0] p_addr = '0;
  logic [31:0] p_dat = '0;
  always @(negedge clk) begin
    if (bus.spr_bus_stb_o) begin
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (bus.spr_bus_stb_o && p_ack) gap_viol++;
    if (bus.spr_bus_stb_o && p_stb && !p_ack &&
        (bus.spr_bus_addr_o != p_addr || bus.spr_bus_dat_o != p_dat ||
         bus.spr_bus_we_o != p_we)) unstable++;
    if (bus.spr_bus_stb_o && bus.spr_gpr_ack_i)
      alog.push_back(bus.spr_bus_addr_o);
    if (bus.done_o) done_cnt++;
    if (bus.err_o) err_cnt++;
    if (bus.err_o && (!bus.done_o || bus.spr_bus_stb_o)) proto++;
    if (bus.rdat_valid_o && (bus.wdat_ready_o || bus.spr_bus_stb_o)) proto++;
    if (bus.rdat_valid_o) rv_cyc++;
    p_ack  = bus.spr_gpr_ack_i;
    p_stb  = bus.spr_bus_stb_o;
    p_we   = bus.spr_bus_we_o;
    p_addr = bus.spr_bus_addr_o;
    p_dat  = bus.spr_bus_dat_o;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    alog.delete();
    rq.delete();
    max_run = 0;
    gap_viol = 0;
    unstable = 0;
    done_cnt = 0;
    err_cnt = 0;
    proto = 0;
    rv_cyc = 0;
    rdat_unstable = 0;
  endtask

  task automatic issue(logic we, logic [4:0] idx, logic [4:0] len);
    int n = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i = we;
    bus.cmd_idx_i = idx;
    bus.cmd_len_i = len;
    while (!bus.cmd_ready_o && n < 50) begin
      step();
      n++;
    end
    chk("cmd_accept", 32'(bus.cmd_ready_o), 32'd1);
    step();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(string tag, int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(done_cnt != 0), 32'd1);
    repeat (2) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i = 1'b0;
    bus.cmd_idx_i = '0;
    bus.cmd_len_i = '0;
    repeat (3) step();
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("rst_stb", 32'(bus.spr_bus_stb_o), 32'd0);
    chk("rst_addr", 32'(bus.spr_bus_addr_o), 32'd0);
    chk("rst_dat", bus.spr_bus_dat_o, 32'd0);
    chk("rst_outs", {28'd0, bus.rdat_valid_o, bus.wdat_ready_o,
                     bus.done_o, bus.err_o}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);

    // single write
    clr();
    wq.push_back(32'hDEADBEEF);
    issue(1'b1, 5'd3, 5'd0);
    wait_done("t1_done", 40);
    chk("t1_addr_cnt", alog.size(), 32'd1);
    if (alog.size() > 0) chk("t1_addr", 32'(alog[0]), 32'h0403);
    chk("t1_mem", mem[3], 32'hDEADBEEF);
    chk("t1_done_cnt", done_cnt, 32'd1);
    chk("t1_err", err_cnt, 32'd0);
    chk("t1_stb_len", max_run, 32'd2);
    chk("t1_wq_empty", wq.size(), 32'd0);

    // read burst wrapping the index
    clr();
    issue(1'b0, 5'd30, 5'd3);
    wait_done("t2_done", 80);
    chk("t2_addr_cnt", alog.size(), 32'd4);
    chk("t2_rd_cnt", rq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [4:0] ix;
      ix = 5'(30 + i);
      if (i < alog.size())
        chk($sformatf("t2_addr%0d", i), 32'(alog[i]), {16'h0, 11'h020, ix});
      if (i < rq.size())
        chk($sformatf("t2_data%0d", i), rq[i], 32'hA000_0000 + 32'(ix));
    end
    chk("t2_gap", gap_viol, 32'd0);
    chk("t2_stable", unstable, 32'd0);

    // read with back-pressure on the first word
    clr();
    blk = 10;
    issue(1'b0, 5'd3, 5'd1);
    wait_done("t3_done", 80);
    chk("t3_rd_cnt", rq.size(), 32'd2);
    if (rq.size() > 1) begin
      chk("t3_data0", rq[0], 32'hDEADBEEF);
      chk("t3_data1", rq[1], 32'hA000_0004);
    end
    chk("t3_rv_cycles", rv_cyc, 32'd12);
    chk("t3_rdat_stable", rdat_unstable, 32'd0);
    chk("t3_proto", proto, 32'd0);
    chk("t3_gap", gap_viol, 32'd0);

    // write with the responder stalled; ack lands in the final cycle
    clr();
    wq.push_back(32'h5A5A_1234);
    issue(1'b1, 5'd9, 5'd0);
    begin
      int n = 0;
      while (!bus.spr_bus_stb_o && n < 20) begin
        step();
        n++;
      end
    end
    stall = 1'b1;
    repeat (6) step();
    stall = 1'b0;
    wait_done("t4_done", 40);
    chk("t4_stb_len", max_run, 32'd8);
    chk("t4_stable", unstable, 32'd0);
    chk("t4_err", err_cnt, 32'd0);
    chk("t4_mem", mem[9], 32'h5A5A_1234);

    // dead responder: timeout
    clr();
    dead = 1'b1;
    issue(1'b0, 5'd5, 5'd2);
    wait_done("t5_done", 40);
    chk("t5_stb_len", max_run, 32'd8);
    chk("t5_err", err_cnt, 32'd1);
    chk("t5_done_cnt", done_cnt, 32'd1);
    chk("t5_no_ack", alog.size(), 32'd0);
    chk("t5_proto", proto, 32'd0);
    chk("t5_idle_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("t5_no_rdat", rv_cyc, 32'd0);
    dead = 1'b0;

    // reset during the second access of a 4-word write
    clr();
    for (int i = 0; i < 4; i++) wq.push_back(32'h1111_0000 + i);
    issue(1'b1, 5'd10, 5'd3);
    begin
      int n = 0;
      while (!(alog.size() == 1 && bus.spr_bus_stb_o) && n < 40) begin
        step();
        n++;
      end
    end
    chk("t6_in_acc", 32'(bus.spr_bus_stb_o), 32'd1);
    rst = 1'b1;
    wq.delete();
    step();
    chk("t6_rst_stb", 32'(bus.spr_bus_stb_o), 32'd0);
    chk("t6_rst_ready", 32'(bus.cmd_ready_o), 32'd0);
    rst = 1'b0;
    step();
    chk("t6_no_done", done_cnt + err_cnt, 32'd0);
    chk("t6_mem10", mem[10], 32'h1111_0000);
    chk("t6_mem11", mem[11], 32'hA000_000B);
    alog.delete();
    wq.push_back(32'h1234_5678);
    issue(1'b1, 5'd7, 5'd0);
    wait_done("t6_next_done", 40);
    chk("t6_next_cnt", alog.size(), 32'd1);
    if (alog.size() > 0) chk("t6_next_addr", 32'(alog[0]), 32'h0407);
    chk("t6_next_mem", mem[7], 32'h1234_5678);
    chk("t6_next_err", err_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
